// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
// The build option ALU_ARB_RR_EN selects round-robin tie-breaking in alu_arb_pick.
package alu_arb_pkg;

    localparam int unsigned NUM_REQ  = 2;
    localparam int unsigned REQ_ID_W = 1;
    localparam int unsigned ST_W     = 3;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE = 3'b001;
    localparam state_t ST_EXEC = 3'b010;
    localparam state_t ST_RESP = 3'b100;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational winner selection between the two request sources.
// ALU_ARB_RR_EN: ties go to !last (round-robin); otherwise source 0 always wins ties.
module alu_arb_pick
    import alu_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0]  valid,
    input  logic                last,
    output logic                any,
    output logic [REQ_ID_W-1:0] win
);

    assign any = |valid;

`ifdef ALU_ARB_RR_EN
    assign win = (valid[0] & valid[1]) ? ~last : ~valid[0];
`else
    logic unused_last;
    assign unused_last = last;
    assign win         = ~valid[0];
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready command sources.
// ALU_ARB_RR_EN: adds the round-robin pointer register used for tie-breaking.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic               req1_valid,
    input  logic [NB_OP-1:0]   req0_op,
    input  logic [NB_OP-1:0]   req1_op,
    input  logic [NB_DATA-1:0] req0_a,
    input  logic [NB_DATA-1:0] req1_a,
    input  logic [NB_DATA-1:0] req0_b,
    input  logic [NB_DATA-1:0] req1_b,
    output logic               req0_ready,
    output logic               req1_ready,
    output logic               rsp0_valid,
    output logic               rsp1_valid,
    output logic [NB_DATA-1:0] rsp_data,
    input  logic               rsp0_ready,
    input  logic               rsp1_ready,
    output logic [NB_OP-1:0]   alu_op,
    output logic [NB_DATA-1:0] alu_a,
    output logic [NB_DATA-1:0] alu_b,
    input  logic [NB_DATA-1:0] alu_result,
    output logic               busy,
    output logic               grant_id
);

    state_t               state_q, state_d;
    logic                 run_q;
    logic [NB_OP-1:0]     alu_op_q, alu_op_d;
    logic [NB_DATA-1:0]   alu_a_q, alu_a_d;
    logic [NB_DATA-1:0]   alu_b_q, alu_b_d;
    logic [NB_DATA-1:0]   rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic                 busy_q, busy_d;
    logic [REQ_ID_W-1:0]  grant_q, grant_d;

    logic                 pick_any;
    logic [REQ_ID_W-1:0]  pick_win;
    logic                 last;
    logic                 accept;
    logic                 rsp_hs;

    alu_arb_pick u_pick (
        .valid ({req1_valid, req0_valid}),
        .last  (last),
        .any   (pick_any),
        .win   (pick_win)
    );

    assign accept     = (state_q == ST_IDLE) && run_q && pick_any;
    assign req0_ready = accept && (pick_win == 1'b0);
    assign req1_ready = accept && (pick_win == 1'b1);
    assign rsp_hs     = (state_q == ST_RESP) && rsp_valid_q[grant_q]
                        && (grant_q[0] ? rsp1_ready : rsp0_ready);

`ifdef ALU_ARB_RR_EN
    logic last_q;

    // Pointer records the owner of the most recently completed response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      last_q <= 1'b1;
        else if (rsp_hs) last_q <= grant_q[0];
    end
    assign last = last_q;
`else
    assign last = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        grant_d     = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    alu_op_d = pick_win[0] ? req1_op : req0_op;
                    alu_a_d  = pick_win[0] ? req1_a  : req0_a;
                    alu_b_d  = pick_win[0] ? req1_b  : req0_b;
                    grant_d  = pick_win;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d           = alu_result;
                rsp_valid_d          = '0;
                rsp_valid_d[grant_q] = 1'b1;
                state_d              = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    rsp_valid_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = '0;
                state_d     = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            run_q       <= 1'b0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            grant_q     <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= 1'b1;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            grant_q     <= grant_d;
        end
    end

    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_data   = rsp_data_q;
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign busy       = busy_q;
    assign grant_id   = grant_q[0];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural stand-in for the shared ALU.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [5:0] req0_op, req1_op;
    logic [7:0] req0_a, req1_a, req0_b, req1_b;
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp_data;
    logic       rsp0_ready, rsp1_ready;
    logic [5:0] alu_op;
    logic [7:0] alu_a, alu_b;
    logic [7:0] alu_result;
    logic       busy, grant_id;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .busy(busy), .grant_id(grant_id)
    );

    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            OP_ADD: alu_result = alu_a + alu_b;
            OP_SUB: alu_result = alu_a - alu_b;
            OP_AND: alu_result = alu_a & alu_b;
            OP_OR:  alu_result = alu_a | alu_b;
            OP_XOR: alu_result = alu_a ^ alu_b;
            OP_NOR: alu_result = ~(alu_a | alu_b);
            OP_SRA: alu_result = 8'($signed(alu_a) >>> alu_b);
            OP_SRL: alu_result = alu_a >> alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int src, input logic v, input logic [5:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        if (src == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Leaves the bench mid-cycle with the requested ready high, or flags a timeout.
    task automatic wait_ready(input int src);
        logic got = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            if ((src == 0) ? req0_ready : req1_ready) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
        end
        check($sformatf("ready_wait_src%0d", src), 32'(got), 32'd1);
    endtask

    // Called just after the accept edge.
    task automatic finish_rsp(input int src, input logic [7:0] exp);
        check("grant_id", 32'(grant_id), 32'(src));
        check("busy_exec", 32'(busy), 32'd1);
        step();
        check("rsp_valid_vec", 32'({rsp1_valid, rsp0_valid}), (src == 0) ? 32'd1 : 32'd2);
        check("rsp_data", 32'(rsp_data), 32'(exp));
        if (src == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        check("rsp_valid_after_hs", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        check("busy_after_hs", 32'(busy), 32'd0);
    endtask

    task automatic run_single(input int src, input logic [5:0] op,
                              input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
        set_req(src, 1'b1, op, a, b);
        wait_ready(src);
        step();
        set_req(src, 1'b0, 6'h00, 8'h00, 8'h00);
        finish_rsp(src, exp);
    endtask

    initial begin
        reset      = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        set_req(0, 1'b1, OP_ADD, 8'h05, 8'h03);
        set_req(1, 1'b0, 6'h00, 8'h00, 8'h00);

        // Reset held with a pending request: everything stays zero.
        step(); step();
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_alu", 32'({alu_op, alu_a, alu_b}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);

        // Startup: no ready until the edge after release, then the first accept.
        reset = 1'b1;
        #1;
        check("start_ready_pre_run", 32'(req0_ready), 32'd0);
        step();
        check("start_ready_run", 32'(req0_ready), 32'd1);
        step();
        set_req(0, 1'b0, 6'h00, 8'h00, 8'h00);
        check("single_alu_a", 32'(alu_a), 32'h05);
        check("single_alu_b", 32'(alu_b), 32'h03);
        check("single_alu_op", 32'(alu_op), 32'(OP_ADD));
        finish_rsp(0, 8'h08);

        // Backpressure on source 1 while source 0 waits.
        set_req(1, 1'b1, OP_SUB, 8'h10, 8'h20);
        wait_ready(1);
        step();
        set_req(1, 1'b0, 6'h00, 8'h00, 8'h00);
        set_req(0, 1'b1, OP_NOR, 8'h00, 8'h00);
        rsp0_ready = 1'b1;
        #1;
        check("bp_req0_ready_exec", 32'(req0_ready), 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid_vec", 32'({rsp1_valid, rsp0_valid}), 32'd2);
            check("bp_rsp_data", 32'(rsp_data), 32'hF0);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_req0_ready", 32'(req0_ready), 32'd0);
            step();
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        step();
        rsp1_ready = 1'b0;
        check("bp_rsp1_cleared", 32'(rsp1_valid), 32'd0);
        check("bp_req0_ready_idle", 32'(req0_ready), 32'd1);
        step();
        set_req(0, 1'b0, 6'h00, 8'h00, 8'h00);
        finish_rsp(0, 8'hFF);

        // Arithmetic shift on source 1 (also leaves source 1 as last owner).
        run_single(1, OP_SRA, 8'h80, 8'h01, 8'hC0);

        // Continuous tie between both sources.
        set_req(0, 1'b1, OP_AND, 8'hF0, 8'h3C);
        set_req(1, 1'b1, OP_OR,  8'hF0, 8'h0F);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
            int exp_w = i % 2;
`else
            int exp_w = 0;
`endif
            check("tie_ready_vec", 32'({req1_ready, req0_ready}), (exp_w == 0) ? 32'd1 : 32'd2);
            step();
            check("tie_grant", 32'(grant_id), 32'(exp_w));
            step();
            check("tie_rsp_valid_vec", 32'({rsp1_valid, rsp0_valid}), (exp_w == 0) ? 32'd1 : 32'd2);
            check("tie_rsp_data", 32'(rsp_data), (exp_w == 0) ? 32'h30 : 32'hFF);
            step();
        end
        set_req(0, 1'b0, 6'h00, 8'h00, 8'h00);
        set_req(1, 1'b0, 6'h00, 8'h00, 8'h00);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        step();

        // Reset during EXEC discards the operation.
        set_req(0, 1'b1, OP_XOR, 8'hAA, 8'hFF);
        wait_ready(0);
        step();
        set_req(0, 1'b0, 6'h00, 8'h00, 8'h00);
        check("midrst_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_alu_a", 32'(alu_a), 32'd0);
        step();
        check("midrst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        reset = 1'b1;
        step();
        check("midrst_no_stale_rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);
        run_single(0, OP_XOR, 8'hAA, 8'hFF, 8'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
